// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS I core: multiply/divide op codes, the
// multiply/divide sequencer states and a two's-complement negate helper.
package mips_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } muldiv_state_t;

    // Widest value the negate helper accepts; callers size-cast the result
    // back down to the width they need.
    localparam int MD_MAX_W = 128;

    function automatic logic [MD_MAX_W-1:0] md_negate(input logic [MD_MAX_W-1:0] v);
        return ~v + MD_MAX_W'(1);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring-divide unit holding the HI/LO pair.
// One operation in flight; WIDTH+1 edges from acceptance to HI/LO commit.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t r_state;
    muldiv_state_t w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [W2-1:0]    r_acc;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_a_raw;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic [CNT_W-1:0] w_cnt_next;
    logic [W2-1:0]    w_acc_next;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_a_raw_next;
    logic             w_is_div_next;
    logic             w_neg_q_next;
    logic             w_neg_r_next;
    logic             w_div0_next;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic             w_done_next;

    muldiv_op_t w_op;
    assign w_op = muldiv_op_t'(op_i);

    // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
    logic             w_signed_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed_op = ~op_i[0];
    assign w_a_neg     = w_signed_op & rs_data_i[WIDTH-1];
    assign w_b_neg     = w_signed_op & rt_data_i[WIDTH-1];
    assign w_a_mag     = w_a_neg ? WIDTH'(md_negate(MD_MAX_W'(rs_data_i))) : rs_data_i;
    assign w_b_mag     = w_b_neg ? WIDTH'(md_negate(MD_MAX_W'(rt_data_i))) : rt_data_i;

    // Shift-add step: low half holds the remaining multiplier bits.
    logic [WIDTH:0] w_mul_sum;
    logic [W2-1:0]  w_mul_acc;

    assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: dividend bits shift out of the low half, quotient bits shift in.
    logic [WIDTH+1:0] w_div_shift;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_ok;
    logic [WIDTH:0]   w_div_rem;
    logic [W2-1:0]    w_div_acc;

    assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {2'b00, r_b};
    assign w_div_ok    = ~w_div_diff[WIDTH+1];
    assign w_div_rem   = w_div_ok ? w_div_diff[WIDTH:0] : w_div_shift[WIDTH:0];
    assign w_div_acc   = {r_acc[W2-1:WIDTH], r_acc[WIDTH-2:0], w_div_ok};

    // Sign fix-up of the finished magnitudes.
    logic [W2-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_prod_fix = r_neg_q ? W2'(md_negate(MD_MAX_W'(r_acc))) : r_acc;
    assign w_quo_fix  = r_neg_q ? WIDTH'(md_negate(MD_MAX_W'(r_acc[WIDTH-1:0])))
                                : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? WIDTH'(md_negate(MD_MAX_W'(r_rem[WIDTH-1:0])))
                                : r_rem[WIDTH-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_acc_next    = r_acc;
        w_rem_next    = r_rem;
        w_b_next      = r_b;
        w_a_raw_next  = r_a_raw;
        w_is_div_next = r_is_div;
        w_neg_q_next  = r_neg_q;
        w_neg_r_next  = r_neg_r;
        w_div0_next   = r_div0;
        w_hi_next     = r_hi;
        w_lo_next     = r_lo;
        w_done_next   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    case (w_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            w_acc_next    = {{WIDTH{1'b0}}, w_a_mag};
                            w_rem_next    = '0;
                            w_b_next      = w_b_mag;
                            w_a_raw_next  = rs_data_i;
                            w_is_div_next = op_i[1];
                            w_neg_q_next  = w_a_neg ^ w_b_neg;
                            w_neg_r_next  = w_a_neg;
                            w_div0_next   = (rt_data_i == '0);
                            w_cnt_next    = '0;
                            w_state_next  = ST_CALC;
                        end
                        OP_MTHI: begin
                            w_hi_next   = rs_data_i;
                            w_done_next = 1'b1;
                        end
                        OP_MTLO: begin
                            w_lo_next   = rs_data_i;
                            w_done_next = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (r_is_div) begin
                    w_acc_next = w_div_acc;
                    w_rem_next = w_div_rem;
                end else begin
                    w_acc_next = w_mul_acc;
                end
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_next = ST_SIGN;
                end
            end
            ST_SIGN: begin
                if (!r_is_div) begin
                    w_hi_next = w_prod_fix[W2-1:WIDTH];
                    w_lo_next = w_prod_fix[WIDTH-1:0];
                end else if (r_div0) begin
                    w_hi_next = r_a_raw;
                    w_lo_next = '1;
                end else begin
                    // Most-negative / -1 lands here naturally: positive 2^(W-1) quotient, zero remainder.
                    w_hi_next = w_rem_fix;
                    w_lo_next = w_quo_fix;
                end
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_b      <= '0;
            r_a_raw  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_acc    <= w_acc_next;
            r_rem    <= w_rem_next;
            r_b      <= w_b_next;
            r_a_raw  <= w_a_raw_next;
            r_is_div <= w_is_div_next;
            r_neg_q  <= w_neg_q_next;
            r_neg_r  <= w_neg_r_next;
            r_div0   <= w_div0_next;
            r_hi     <= w_hi_next;
            r_lo     <= w_lo_next;
            r_done   <= w_done_next;
        end
    end

    assign busy_o = (r_state != ST_IDLE);
    assign done_o = r_done;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS I core, providing the HI/LO register pair and the MULT, MULTU, DIV, DIVU, MTHI and MTLO operations alongside the combinational ALU. It is parametrised in operand width and runs a radix-2 shift-add / restoring-divide sequence of WIDTH iterations. It exposes a start/busy/done handshake so the controller can stall MFHI/MFLO until a result is committed. HI and LO are architectural state held inside this block.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4 and even.
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- start_i  in  1  operation request; accepted only on an edge where busy_o=0.
- op_i  in  3  operation code, muldiv_op_t.
- rs_data_i  in  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO source.
- rt_data_i  in  WIDTH  operand B: multiplier or divisor.
- busy_o  out  1  high while an operation is in flight.
- done_o  out  1  one-cycle pulse when HI/LO have been committed.
- hi_o  out  WIDTH  HI register (remainder / product upper half).
- lo_o  out  WIDTH  LO register (quotient / product lower half).

## Operation
- Op codes: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
- A reserved op with start_i=1 is ignored: no state change and no done_o.
- FSM states: IDLE, CALC, SIGN.
- IDLE + start_i + MULT/MULTU/DIV/DIVU:
  - latch operands; for signed ops convert each to magnitude and record the result signs;
  - clear the iteration counter; go to CALC.
- IDLE + start_i + MTHI/MTLO: write rs_data_i to HI (MTHI) or LO (MTLO) on that edge; done_o pulses the following cycle; stay in IDLE.
- CALC: one radix-2 step per cycle for WIDTH cycles.
  - Multiply: 2·WIDTH-bit accumulator.
  - Divide: restoring algorithm with a WIDTH+1-bit partial remainder.
  - After the WIDTH-th step, go to SIGN.
- SIGN: apply sign fix-up, write HI/LO, assert done_o next cycle, return to IDLE.
  - Signed product: negate the full 2·WIDTH-bit value if the operand signs differ.
  - Signed quotient: negative iff the operand signs differ.
  - Signed remainder: takes the dividend's sign.
- Divide by zero (either signedness): LO = all ones, HI = rs_data_i unmodified; still takes full latency.
- Signed overflow, most-negative ÷ −1: LO = most-negative value, HI = 0; no exception.
- Magnitude of the most-negative operand is handled as an unsigned WIDTH-bit value, never truncated.
- start_i while busy_o=1 is ignored; operands are not re-latched.
- HI/LO are held between operations; hi_o/lo_o are driven directly from the registers.

## Timing
- Reset values: state IDLE; busy_o=0; done_o=0; hi_o=0; lo_o=0; counter=0; internal datapath registers=0.
- Reset is asynchronous and may assert in any state. The in-flight operation is abandoned and HI/LO are cleared.
- Let edge E be the edge that accepts the request:
  - busy_o goes high after E;
  - CALC occupies edges E+1 … E+WIDTH;
  - HI/LO are written at edge E+WIDTH+1;
  - busy_o falls and done_o rises after edge E+WIDTH+1;
  - done_o falls after edge E+WIDTH+2.
  - Total latency is WIDTH+1 edges; 33 for WIDTH=32.
- A new start_i is accepted on the edge where done_o is high (back-to-back operations).
- MTHI/MTLO: HI/LO update at E, done_o is high for the cycle after E, and busy_o stays 0.
- No combinational path from any input to any output.

## Structure
- Shared package (mips_pkg):
  - muldiv_op_t enum and its codes;
  - FSM state enum;
  - a negate-to-width function reused by the sign fix-up.
- Single module; no sub-module. Multiply and divide share the accumulator and counter registers.

## Test plan
- MULT, rs=0xFFFFFFFD (−3), rt=5 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done_o for one cycle.
- MULTU, rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV, rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU, rs=7, rt=0 → lo=0xFFFFFFFF, hi=0x00000007; latency unchanged.
- Handshake:
  - MTLO 0x1234 → lo=0x1234 next edge, busy_o never high;
  - start_i pulsed mid-DIVU with different operands → ignored, original result committed;
  - back-to-back MULTU on the done_o cycle is accepted.
- Reset and width:
  - rst_ni asserted at iteration 10 of a MULT → busy_o, done_o, hi_o, lo_o all 0 immediately; the next MULT runs normally.
  - WIDTH=8: MULT 0x80 × 0x80 → hi=0x40, lo=0x00.
